mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the instruction-fetch port and the load/store port.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port, the shared memory
// and the arbiter that sits between them. The arbiter takes the slave view;
// whatever drives the requests and the memory read data takes the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction-fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // Load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // Shared single-port memory
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Status
    logic          busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// load/store port. One transaction is in flight at a time: it is issued for
// one cycle, waits MEM_LAT cycles for the memory, and the response is handed
// back to the requester that won. The data port normally wins; a saturating
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// wins that left a fetch waiting.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.slave      bus
);

    localparam int WCW = $clog2(MEM_LAT + 1);
    localparam int SCW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [SCW-1:0] starve_cnt;
    logic           win_d;
    logic           lat_we;
    logic           d_pick;

    // Saturating increment of the starvation counter.
    function automatic logic [SCW-1:0] starve_inc(input logic [SCW-1:0] cnt);
        if (cnt == SCW'(STARVE_MAX)) begin
            return cnt;
        end
        return cnt + SCW'(1);
    endfunction

    // Data port wins whenever it asks, unless fetch is waiting and has been
    // passed over STARVE_MAX times in a row.
    assign d_pick = bus.d_req && !(bus.if_req && (starve_cnt == SCW'(STARVE_MAX)));

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            starve_cnt    <= '0;
            win_d         <= 1'b0;
            lat_we        <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= {DW{1'b0}};
            bus.d_gnt     <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= {DW{1'b0}};
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {AW{1'b0}};
            bus.mem_wdata <= {DW{1'b0}};
            bus.busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless a state below raises them.
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        state      <= ISSUE;
                        bus.busy   <= 1'b1;
                        bus.mem_en <= 1'b1;
                        if (d_pick) begin
                            win_d         <= 1'b1;
                            lat_we        <= bus.d_we;
                            bus.d_gnt     <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            starve_cnt    <= bus.if_req ? starve_inc(starve_cnt) : '0;
                        end else begin
                            win_d         <= 1'b0;
                            lat_we        <= 1'b0;
                            bus.if_gnt    <= 1'b1;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= {DW{1'b0}};
                            starve_cnt    <= '0;
                        end
                    end
                end

                ISSUE: begin
                    wait_cnt <= WCW'(MEM_LAT);
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == WCW'(1)) begin
                        // Memory data is valid in this last wait cycle.
                        wait_cnt <= '0;
                        state    <= RESP;
                        if (win_d) begin
                            bus.d_rvalid <= 1'b1;
                            bus.d_rdata  <= lat_we ? {DW{1'b0}} : bus.mem_rdata;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end

                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, a transaction-level model
// compared against the outputs every cycle, a small memory responder, and
// literal checks on the logged grant/response timeline of each scenario.
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    localparam int K_IFG = 0;
    localparam int K_DG  = 1;
    localparam int K_IFR = 2;
    localparam int K_DR  = 3;
    localparam int K_MEN = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic        w;
    } ev_t;

    ev_t evq[$];

    int cyc     = 0;
    bit started = 1'b0;
    int nvec    = 0;
    int nerr    = 0;

    // Transaction-level model state
    int          acc      = -1000;
    int          nxt_idle = 0;
    int          starve   = 0;
    bit          m_dw;
    bit          tr_d;
    bit          tr_we;
    logic [31:0] tr_addr;
    logic [31:0] tr_wdata;
    logic [31:0] tr_data;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    logic [31:0] exp_mem_addr = '0;
    bit          c_iss, c_rsp, c_busy;

    logic [31:0] model_mem [256];
    logic [31:0] env_mem   [256];
    int          rd_due  = -1;
    logic [31:0] rd_addr = '0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ev_idx(input int kind, input int nth);
        int n = 0;
        foreach (evq[i]) begin
            if (evq[i].kind == kind) begin
                if (n == nth) return i;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int ev_count(input int kind);
        int n = 0;
        foreach (evq[i]) if (evq[i].kind == kind) n++;
        return n;
    endfunction

    function automatic int ev_cyc(input int kind, input int nth);
        int i = ev_idx(kind, nth);
        return (i < 0) ? -1 : evq[i].cyc;
    endfunction

    function automatic logic [31:0] ev_a(input int kind, input int nth);
        int i = ev_idx(kind, nth);
        return (i < 0) ? 32'hFFFF_FFFF : evq[i].a;
    endfunction

    function automatic int gnt_idx(input int nth);
        int n = 0;
        foreach (evq[i]) begin
            if (evq[i].kind == K_IFG || evq[i].kind == K_DG) begin
                if (n == nth) return i;
                n++;
            end
        end
        return -1;
    endfunction

    // Model: decides acceptance and winner at each clock edge from the rules.
    initial begin
        forever begin
            @(posedge clk);
            if (reset && started && cyc >= nxt_idle && (bus.if_req || bus.d_req)) begin
                m_dw     = bus.d_req && !(bus.if_req && starve == STARVE_MAX);
                acc      = cyc;
                nxt_idle = cyc + MEM_LAT + 3;
                if (m_dw) begin
                    tr_d     = 1'b1;
                    tr_we    = bus.d_we;
                    tr_addr  = bus.d_addr;
                    tr_wdata = bus.d_wdata;
                    if (bus.d_we) begin
                        model_mem[widx(bus.d_addr)] = bus.d_wdata;
                        tr_data = '0;
                    end else begin
                        tr_data = model_mem[widx(bus.d_addr)];
                    end
                    if (bus.if_req) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
                    else            starve = 0;
                end else begin
                    tr_d     = 1'b0;
                    tr_we    = 1'b0;
                    tr_addr  = bus.if_addr;
                    tr_wdata = '0;
                    tr_data  = model_mem[widx(bus.if_addr)];
                    starve   = 0;
                end
            end
            cyc++;
        end
    end

    // Model: an asserted reset drops everything at once.
    initial begin
        forever begin
            @(negedge reset);
            started      = 1'b1;
            acc          = -1000;
            nxt_idle     = 0;
            starve       = 0;
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
            exp_mem_addr = '0;
        end
    end

    // Memory responder: performs writes at issue, returns read data MEM_LAT cycles later.
    initial begin
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (started && bus.mem_en) begin
                if (bus.mem_we) begin
                    env_mem[widx(bus.mem_addr)] = bus.mem_wdata;
                end else begin
                    rd_due  = cyc + MEM_LAT;
                    rd_addr = bus.mem_addr;
                end
            end
            if (cyc == rd_due) bus.mem_rdata = env_mem[widx(rd_addr)];
            else               bus.mem_rdata = 32'hBAD0_0000 + 32'(cyc);
        end
    end

    // Every-cycle compare against the model, plus event logging.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                c_iss  = (cyc == acc + 1);
                c_rsp  = (cyc == acc + MEM_LAT + 2);
                c_busy = (cyc >= acc + 1) && (cyc <= acc + MEM_LAT + 2);
                if (c_iss) exp_mem_addr = tr_addr;
                if (c_rsp) begin
                    if (tr_d) exp_d_rdata  = tr_data;
                    else      exp_if_rdata = tr_data;
                end
                chk("if_gnt",    bus.if_gnt,    c_iss && !tr_d);
                chk("d_gnt",     bus.d_gnt,     c_iss && tr_d);
                chk("mem_en",    bus.mem_en,    c_iss);
                if (c_iss) begin
                    chk("mem_we", bus.mem_we, tr_d && tr_we);
                    if (tr_d && tr_we) chk("mem_wdata", bus.mem_wdata, tr_wdata);
                end
                chk("if_rvalid", bus.if_rvalid, c_rsp && !tr_d);
                chk("d_rvalid",  bus.d_rvalid,  c_rsp && tr_d);
                chk("busy",      bus.busy,      c_busy);
                chk("if_rdata",  bus.if_rdata,  exp_if_rdata);
                chk("d_rdata",   bus.d_rdata,   exp_d_rdata);
                chk("mem_addr",  bus.mem_addr,  exp_mem_addr);

                if (bus.if_gnt)    evq.push_back('{cyc, K_IFG, 32'h0, 32'h0, 1'b0});
                if (bus.d_gnt)     evq.push_back('{cyc, K_DG,  32'h0, 32'h0, 1'b0});
                if (bus.if_rvalid) evq.push_back('{cyc, K_IFR, bus.if_rdata, 32'h0, 1'b0});
                if (bus.d_rvalid)  evq.push_back('{cyc, K_DR,  bus.d_rdata, 32'h0, 1'b0});
                if (bus.mem_en)    evq.push_back('{cyc, K_MEN, bus.mem_addr, bus.mem_wdata, bus.mem_we});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed scenarios
    initial begin
        int c0;
        int ix;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'hC0DE_0000 | 32'(i);
            env_mem[i]   = 32'hC0DE_0000 | 32'(i);
        end
        model_mem[4] = 32'hDEAD_BEEF;
        env_mem[4]   = 32'hDEAD_BEEF;

        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        #2 reset = 1'b0;
        tick(1);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_mem_en",   bus.mem_en,   0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        tick(2);
        reset = 1'b1;
        tick(2);

        // 1: single fetch of 0x10
        evq.delete();
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick(1);
        bus.if_req = 1'b0;
        tick(8);
        chk("t1_if_gnt_cycle",   ev_cyc(K_IFG, 0), c0 + 1);
        chk("t1_mem_en_cycle",   ev_cyc(K_MEN, 0), c0 + 1);
        chk("t1_mem_addr",       ev_a(K_MEN, 0),   32'h10);
        ix = ev_idx(K_MEN, 0);
        chk("t1_mem_we",         (ix < 0) ? 1'b1 : evq[ix].w, 0);
        chk("t1_if_rvalid_cycle", ev_cyc(K_IFR, 0), c0 + 4);
        chk("t1_if_rdata",       ev_a(K_IFR, 0),   32'hDEAD_BEEF);

        // 2: single store
        evq.delete();
        c0 = cyc;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h0000_1234;
        tick(1);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick(8);
        chk("t2_d_gnt_cycle",    ev_cyc(K_DG, 0),  c0 + 1);
        ix = ev_idx(K_MEN, 0);
        chk("t2_mem_we",         (ix < 0) ? 1'b0 : evq[ix].w, 1);
        chk("t2_mem_wdata",      (ix < 0) ? 32'hFFFF_FFFF : evq[ix].b, 32'h1234);
        chk("t2_mem_en_count",   ev_count(K_MEN),  1);
        chk("t2_d_rvalid_cycle", ev_cyc(K_DR, 0),  c0 + 4);
        chk("t2_d_rdata",        ev_a(K_DR, 0),    0);
        chk("t2_if_events",      ev_count(K_IFG) + ev_count(K_IFR), 0);

        // 3: simultaneous requests
        evq.delete();
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h24;
        bus.d_req  = 1'b1; bus.d_addr  = 32'h48;
        tick(1);
        bus.d_req = 1'b0;
        tick(5);
        bus.if_req = 1'b0;
        tick(8);
        chk("t3_d_gnt_cycle",  ev_cyc(K_DG, 0),  c0 + 1);
        chk("t3_if_gnt_cycle", ev_cyc(K_IFG, 0), c0 + 6);

        // 4: both held high, starvation forcing
        evq.delete();
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        bus.d_req  = 1'b1; bus.d_addr  = 32'h50;
        tick(47);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        tick(8);
        chk("t4_gnt_count", ev_count(K_IFG) + ev_count(K_DG), 10);
        for (int k = 0; k < 10; k++) begin
            ix = gnt_idx(k);
            chk("t4_gnt_who",   (ix < 0) ? -1 : evq[ix].kind, (k % 5 == 4) ? K_IFG : K_DG);
            chk("t4_gnt_cycle", (ix < 0) ? -1 : evq[ix].cyc,  c0 + 1 + 5 * k);
        end

        // 5: reset in the middle of a load
        evq.delete();
        c0 = cyc;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        tick(1);
        bus.d_req = 1'b0;
        tick(1);
        #2 reset = 1'b0;
        #1;
        chk("t5_busy_in_reset",     bus.busy,     0);
        chk("t5_mem_addr_in_reset", bus.mem_addr, 0);
        tick(2);
        reset = 1'b1;
        tick(8);
        chk("t5_no_d_rvalid", ev_count(K_DR), 0);
        evq.delete();
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick(1);
        bus.if_req = 1'b0;
        tick(8);
        chk("t5_if_gnt_cycle",    ev_cyc(K_IFG, 0), c0 + 1);
        chk("t5_if_rvalid_cycle", ev_cyc(K_IFR, 0), c0 + 4);
        chk("t5_if_rdata",        ev_a(K_IFR, 0),   32'hDEAD_BEEF);

        // 6: single requester held continuously
        evq.delete();
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h14;
        tick(17);
        bus.if_req = 1'b0;
        tick(8);
        chk("t6_gnt_count", ev_count(K_IFG), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t6_gnt_cycle", ev_cyc(K_IFG, k), c0 + 1 + 5 * k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
